// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide: radix-4 Booth multiply (16 steps), non-restoring divide (32 steps + fix).
// Optional macro MULDIV_UNSIGNED_EN adds the opUnsigned input for unsigned operation.
//
// state | meaning
// IDLE  | waiting for start; Z outputs hold the last result
// MUL   | one Booth bit-pair step per edge, Z written on the 16th
// DIV   | one non-restoring step per edge, 32 in total
// FIX   | remainder correction and sign application, Z written
// DONE  | single-cycle done pulse, then back to IDLE
module muldiv_unit #(
  parameter logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        op,
`ifdef MULDIV_UNSIGNED_EN
  input  logic        opUnsigned,
`endif
  input  logic [31:0] YdataOut,
  input  logic [31:0] BusMuxOut,
  output logic [31:0] ZhighdataOut,
  output logic [31:0] ZlowdataOut,
  output logic        busy,
  output logic        done,
  output logic        divByZero
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      state_q;
  logic [4:0]  count_q;
  logic [31:0] a_q;
  logic        mul_fix_q;
  logic [63:0] mcand_q;
  logic [63:0] acc_q;
  logic [32:0] bsh_q;
  logic [33:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        q_neg_q;
  logic        r_neg_q;

  logic        op_uns;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] booth_add;
  logic [63:0] acc_d;
  logic [63:0] prod;
  logic [33:0] rem_sh;
  logic [33:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] rem_fix;
  logic [31:0] q_final;
  logic [31:0] r_final;

`ifdef MULDIV_UNSIGNED_EN
  assign op_uns = opUnsigned;
`else
  assign op_uns = 1'b0;
`endif

  assign a_neg = ~op_uns & YdataOut[31];
  assign b_neg = ~op_uns & BusMuxOut[31];
  assign a_mag = a_neg ? -YdataOut : YdataOut;
  assign b_mag = b_neg ? -BusMuxOut : BusMuxOut;

  always_comb begin
    booth_add = 64'h0;
    case (bsh_q[2:0])
      3'b001, 3'b010: booth_add = mcand_q;
      3'b011:         booth_add = mcand_q << 1;
      3'b100:         booth_add = -(mcand_q << 1);
      3'b101, 3'b110: booth_add = -mcand_q;
      default:        booth_add = 64'h0;
    endcase
  end

  // Booth treats B as signed; an unsigned B with its MSB set needs A*2^32 added back.
  assign acc_d = acc_q + booth_add;
  assign prod  = acc_d + (mul_fix_q ? {a_q, 32'h0} : 64'h0);

  assign rem_sh  = {rem_q[32:0], quo_q[31]};
  assign rem_d   = rem_q[33] ? rem_sh + {2'b00, dvs_q} : rem_sh - {2'b00, dvs_q};
  assign quo_d   = {quo_q[30:0], ~rem_d[33]};
  assign rem_fix = rem_q[31:0] + (rem_q[33] ? dvs_q : 32'h0);
  assign q_final = q_neg_q ? -quo_q : quo_q;
  assign r_final = r_neg_q ? -rem_fix : rem_fix;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q      <= S_IDLE;
      count_q      <= 5'd0;
      a_q          <= 32'h0;
      mul_fix_q    <= 1'b0;
      mcand_q      <= 64'h0;
      acc_q        <= 64'h0;
      bsh_q        <= 33'h0;
      rem_q        <= 34'h0;
      quo_q        <= 32'h0;
      dvs_q        <= 32'h0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      ZhighdataOut <= 32'h0;
      ZlowdataOut  <= 32'h0;
      busy         <= 1'b0;
      done         <= 1'b0;
      divByZero    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q       <= YdataOut;
            mul_fix_q <= op_uns & BusMuxOut[31];
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            count_q   <= 5'd0;
            divByZero <= 1'b0;
            if (!op) begin
              state_q <= S_MUL;
              busy    <= 1'b1;
              mcand_q <= op_uns ? {32'h0, YdataOut} : {{32{YdataOut[31]}}, YdataOut};
              bsh_q   <= {BusMuxOut, 1'b0};
              acc_q   <= 64'h0;
            end else if (BusMuxOut == 32'h0) begin
              state_q      <= S_DONE;
              done         <= 1'b1;
              divByZero    <= 1'b1;
              ZhighdataOut <= YdataOut;
              ZlowdataOut  <= DIV0_QUOTIENT;
            end else begin
              state_q <= S_DIV;
              busy    <= 1'b1;
              rem_q   <= 34'h0;
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
            end
          end
        end
        S_MUL: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 2;
          bsh_q   <= bsh_q >> 2;
          if (count_q == 5'd15) begin
            state_q      <= S_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            ZhighdataOut <= prod[63:32];
            ZlowdataOut  <= prod[31:0];
          end else begin
            count_q <= count_q + 5'd1;
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (count_q == 5'd31) begin
            state_q <= S_FIX;
          end else begin
            count_q <= count_q + 5'd1;
          end
        end
        S_FIX: begin
          state_q      <= S_DONE;
          busy         <= 1'b0;
          done         <= 1'b1;
          ZhighdataOut <= r_final;
          ZlowdataOut  <= q_final;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, handshake corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        op_s  = 1'b0;
  logic        uns_s = 1'b0;
  logic [31:0] ya    = 32'h0;
  logic [31:0] bm    = 32'h0;
  logic [31:0] zhi, zlo;
  logic        busy, done, dz;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_hi = 32'h0;
  logic [31:0] prev_lo = 32'h0;

  always #5 clock = ~clock;

  muldiv_unit dut (
    .clock(clock),
    .clear(clear),
    .start(start),
    .op(op_s),
`ifdef MULDIV_UNSIGNED_EN
    .opUnsigned(uns_s),
`endif
    .YdataOut(ya),
    .BusMuxOut(bm),
    .ZhighdataOut(zhi),
    .ZlowdataOut(zlo),
    .busy(busy),
    .done(done),
    .divByZero(dz)
  );

  typedef struct {
    logic        o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero.
  task automatic model(input logic o, input logic u, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic z);
    logic [63:0] r64;
    longint sa, sb, t;
    z = 1'b0;
    if (!o) begin
      if (u) r64 = {32'h0, a} * {32'h0, b};
      else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t = sa * sb;
        r64 = t;
      end
      hi = r64[63:32];
      lo = r64[31:0];
    end else if (b == 32'h0) begin
      hi = a;
      lo = 32'hFFFFFFFF;
      z  = 1'b1;
    end else if (u) begin
      r64 = {32'h0, a} / {32'h0, b};
      lo = r64[31:0];
      r64 = {32'h0, a} % {32'h0, b};
      hi = r64[31:0];
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      t = sa / sb;
      r64 = t;
      lo = r64[31:0];
      t = sa % sb;
      r64 = t;
      hi = r64[31:0];
    end
  endtask

  task automatic do_op(input logic o, input logic u, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed, input string tag);
    int exp_lat, lat, busy_n;
    bit hold_bad;
    exp_lat = !o ? 16 : ((b == 32'h0) ? 0 : 33);
    @(negedge clock);
    op_s = o; uns_s = u; ya = a; bm = b; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = -1; busy_n = 0; hold_bad = 1'b0;
    for (int i = 0; i < 50 && lat < 0; i++) begin
      @(negedge clock);
      if (done) lat = i;
      else begin
        if (busy) busy_n++;
        if (zhi !== prev_hi || zlo !== prev_lo) hold_bad = 1'b1;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
    chk({tag, "_z_hold"}, 64'(hold_bad), 64'(0));
    chk({tag, "_hi"}, 64'(zhi), 64'(eh));
    chk({tag, "_lo"}, 64'(zlo), 64'(el));
    chk({tag, "_dz"}, 64'(dz), 64'(ed));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    @(negedge clock);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    int n_done, done_at;
    logic [31:0] cap_hi, cap_lo, eh, el;
    logic cap_dz, ed, ro, ru;
    logic [31:0] ra, rb;

    vecs[0] = '{1'b0, 32'd6,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEE, 1'b0};
    vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[5] = '{1'b1, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{1'b0, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0};
    vecs[7] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[8] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[9] = '{1'b1, 32'd0,        32'd5,        32'h00000000, 32'h00000000, 1'b0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_dz", 64'(dz), 64'(0));
    chk("reset_hi", 64'(zhi), 64'(0));
    chk("reset_lo", 64'(zlo), 64'(0));
    clear = 1'b1;

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].o, 1'b0, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
            $sformatf("vec%0d", i));

    // Extra starts mid-MUL and during DONE must be ignored.
    @(negedge clock);
    op_s = 1'b0; uns_s = 1'b0; ya = 32'd9; bm = 32'd10; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n_done = 0; done_at = -1; cap_hi = 32'h0; cap_lo = 32'h0; cap_dz = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = i; cap_hi = zhi; cap_lo = zlo; cap_dz = dz;
        end
      end
      if (i == 18) begin
        chk("ign_busy_after", 64'(busy), 64'(0));
      end
      if (i == 4)  begin op_s = 1'b1; ya = 32'd1; bm = 32'd0; start = 1'b1; end
      if (i == 5)  start = 1'b0;
      if (i == 15) start = 1'b1;
      if (i == 17) start = 1'b0;
    end
    chk("ign_done_count", 64'(n_done), 64'(1));
    chk("ign_done_at", 64'(done_at), 64'(16));
    chk("ign_hi", 64'(cap_hi), 64'(0));
    chk("ign_lo", 64'(cap_lo), 64'(90));
    chk("ign_dz", 64'(cap_dz), 64'(0));
    prev_hi = 32'h0; prev_lo = 32'd90;

    // Reset in the middle of a divide aborts it with no done.
    @(negedge clock);
    op_s = 1'b1; ya = 32'd100; bm = 32'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (done) n_done++;
      if (i == 9) clear = 1'b0;
      if (i == 10) begin
        clear = 1'b1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hi", 64'(zhi), 64'(0));
        chk("abort_lo", 64'(zlo), 64'(0));
        chk("abort_dz", 64'(dz), 64'(0));
      end
    end
    chk("abort_no_done", 64'(n_done), 64'(0));
    prev_hi = 32'h0; prev_lo = 32'h0;
    do_op(1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
`ifdef MULDIV_UNSIGNED_EN
      ru = 1'($urandom_range(0, 1));
`else
      ru = 1'b0;
`endif
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      model(ro, ru, ra, rb, eh, el, ed);
      do_op(ro, ru, ra, rb, eh, el, ed, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
